// File: rtl/front_panel_ctl_pkg.sv
// Shared PDP-8/e panel definitions: major-state codes used by the sequencer,
// panel op codes for the datapath decoder, and switch indices.
package front_panel_ctl_pkg;

    localparam int MS_W = 5;

    localparam logic [MS_W-1:0] H0 = 5'd0;
    localparam logic [MS_W-1:0] HW = 5'd1;
    localparam logic [MS_W-1:0] H1 = 5'd2;
    localparam logic [MS_W-1:0] H2 = 5'd3;
    localparam logic [MS_W-1:0] H3 = 5'd4;
    localparam logic [MS_W-1:0] F0 = 5'd5;
    localparam logic [MS_W-1:0] F1 = 5'd6;
    localparam logic [MS_W-1:0] F2 = 5'd7;
    localparam logic [MS_W-1:0] F3 = 5'd8;
    localparam logic [MS_W-1:0] D0 = 5'd9;
    localparam logic [MS_W-1:0] D1 = 5'd10;
    localparam logic [MS_W-1:0] D2 = 5'd11;
    localparam logic [MS_W-1:0] D3 = 5'd12;
    localparam logic [MS_W-1:0] E0 = 5'd13;
    localparam logic [MS_W-1:0] E1 = 5'd14;
    localparam logic [MS_W-1:0] E2 = 5'd15;
    localparam logic [MS_W-1:0] E3 = 5'd16;

    localparam logic [1:0] FP_NONE  = 2'd0;
    localparam logic [1:0] FP_ALOAD = 2'd1;
    localparam logic [1:0] FP_EXAM  = 2'd2;
    localparam logic [1:0] FP_DEP   = 2'd3;

    localparam int SW_HALT  = 0;
    localparam int SW_SING  = 1;
    localparam int SW_CONT  = 2;
    localparam int SW_ALOAD = 3;
    localparam int SW_EXAM  = 4;
    localparam int SW_DEP   = 5;
    localparam int SW_NUM   = 6;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_REQ  = 2'd1,
        P_RUN  = 2'd2,
        P_DONE = 2'd3
    } panel_state_e;

    // Simultaneous op keys resolve dep > exam > addr_load.
    function automatic logic [1:0] fp_op_select(input logic dep, input logic exam,
                                                input logic aload);
        if (dep) begin
            return FP_DEP;
        end else if (exam) begin
            return FP_EXAM;
        end else if (aload) begin
            return FP_ALOAD;
        end else begin
            return FP_NONE;
        end
    endfunction

endpackage

// File: rtl/front_panel_ctl_if.sv
// Panel <-> major-state sequencer handshake bundle.
interface front_panel_ctl_if;
    import front_panel_ctl_pkg::*;

    logic [MS_W-1:0] state;
    logic            halt;
    logic            single_step;
    logic            cont;
    logic            trigger;
    logic [1:0]      fp_op;

    modport master (input state, output halt, output single_step, output cont,
                    output trigger, output fp_op);
    modport slave  (output state, input halt, input single_step, input cont,
                    input trigger, input fp_op);
endinterface

// File: rtl/front_panel_ctl_switch_debounce.sv
// One front-panel switch: 2-flop synchronizer plus stability counter.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter bit ARM_ON_RELEASE  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             can_rise_s;
    logic             hold_s;

    // Synchronizer is left out of reset so a key held through reset is still seen as held.
    always_ff @(posedge clk) begin
        sync1_r <= raw;
        sync2_r <= sync1_r;
    end

    // Momentary keys may only rise after they have been seen released since reset.
    assign can_rise_s = armed_r | ~ARM_ON_RELEASE;
    assign hold_s     = (sync2_r == level_r) || (!level_r && !can_rise_s);

    // Stability counter and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b0;
            armed_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            armed_r <= armed_r | ~sync2_r;
            if (hold_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign level = level_r;
endmodule

// File: rtl/front_panel_ctl.sv
// PDP-8/e front-panel controller: debounced switches become halt/single_step
// levels, a one-shot cont pulse and a trigger/fp_op handshake with the sequencer.
module front_panel_ctl
    import front_panel_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_halt,
    input  logic sw_sing_step,
    input  logic sw_cont,
    input  logic sw_addr_load,
    input  logic sw_exam,
    input  logic sw_dep,
    front_panel_ctl_if.master seq
);
    logic [SW_NUM-1:0] raw_s;
    logic [SW_NUM-1:0] level_s;
    logic [3:0]        key_q_r;
    logic [3:0]        key_rise_s;

    panel_state_e pstate_r, pstate_n;
    logic         trigger_r, trigger_n;
    logic [1:0]   fp_op_r, fp_op_n;
    logic         op_pend_r, op_pend_n;
    logic [1:0]   op_code_r, op_code_n;
    logic         cont_pend_r, cont_pend_n;
    logic         cont_r, cont_n;

    logic [MS_W-1:0] st_s;
    logic            halted_s;
    logic            panel_ok_s;
    logic            step_point_s;
    logic            op_accept_s;
    logic            cont_fire_s;

    assign raw_s = {sw_dep, sw_exam, sw_addr_load, sw_cont, sw_sing_step, sw_halt};

    for (genvar i = 0; i < SW_NUM; i++) begin : g_deb
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .ARM_ON_RELEASE (i >= SW_CONT)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_s[i]),
            .level(level_s[i])
        );
    end

    // Key bits: [0] cont, [1] addr_load, [2] exam, [3] dep.
    assign key_rise_s = level_s[SW_DEP:SW_CONT] & ~key_q_r;

    assign st_s         = seq.state;
    assign halted_s     = (st_s == H0) || (st_s == HW);
    assign panel_ok_s   = halted_s || (st_s == H1) || (st_s == H2) || (st_s == H3);
    assign step_point_s = (st_s == F0) || (st_s == D0) || (st_s == E0);
    assign op_accept_s  = (|key_rise_s[3:1]) && !op_pend_r && (pstate_r == P_IDLE) && halted_s;
    // A waiting op at HW takes precedence so deposit-then-continue ordering holds.
    assign cont_fire_s  = cont_pend_r && (pstate_r == P_IDLE) &&
                          (((st_s == HW) && !op_pend_r) || (step_point_s && level_s[SW_SING]));

    // Request capture, cont pulse and panel FSM next state.
    always_comb begin
        pstate_n    = pstate_r;
        trigger_n   = trigger_r;
        fp_op_n     = fp_op_r;
        op_pend_n   = op_pend_r;
        op_code_n   = op_code_r;
        cont_n      = cont_fire_s;
        cont_pend_n = (cont_pend_r && !cont_fire_s) || key_rise_s[0];

        if (op_accept_s) begin
            op_pend_n = 1'b1;
            op_code_n = fp_op_select(key_rise_s[3], key_rise_s[2], key_rise_s[1]);
        end else begin
            op_code_n = op_code_r;
        end

        case (pstate_r)
            P_IDLE: begin
                if (op_pend_r && (st_s == HW)) begin
                    pstate_n  = P_REQ;
                    trigger_n = 1'b1;
                    fp_op_n   = op_code_r;
                    op_pend_n = 1'b0;
                end else begin
                    pstate_n = P_IDLE;
                end
            end
            P_REQ: begin
                if (!panel_ok_s) begin
                    pstate_n  = P_IDLE;
                    trigger_n = 1'b0;
                    fp_op_n   = FP_NONE;
                end else if (st_s == H1) begin
                    pstate_n  = P_RUN;
                    trigger_n = 1'b0;
                end else begin
                    pstate_n = P_REQ;
                end
            end
            P_RUN: begin
                if (!panel_ok_s) begin
                    pstate_n = P_IDLE;
                    fp_op_n  = FP_NONE;
                end else if (st_s == H3) begin
                    pstate_n = P_DONE;
                end else begin
                    pstate_n = P_RUN;
                end
            end
            P_DONE: begin
                if (!panel_ok_s || (st_s == H0)) begin
                    pstate_n = P_IDLE;
                    fp_op_n  = FP_NONE;
                end else begin
                    pstate_n = P_DONE;
                end
            end
            default: begin
                pstate_n  = P_IDLE;
                trigger_n = 1'b0;
                fp_op_n   = FP_NONE;
            end
        endcase
    end

    // Panel state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_r    <= P_IDLE;
            trigger_r   <= 1'b0;
            fp_op_r     <= FP_NONE;
            op_pend_r   <= 1'b0;
            op_code_r   <= FP_NONE;
            cont_pend_r <= 1'b0;
            cont_r      <= 1'b0;
            key_q_r     <= 4'b0000;
        end else begin
            pstate_r    <= pstate_n;
            trigger_r   <= trigger_n;
            fp_op_r     <= fp_op_n;
            op_pend_r   <= op_pend_n;
            op_code_r   <= op_code_n;
            cont_pend_r <= cont_pend_n;
            cont_r      <= cont_n;
            key_q_r     <= level_s[SW_DEP:SW_CONT];
        end
    end

    assign seq.halt        = level_s[SW_HALT];
    assign seq.single_step = level_s[SW_SING];
    assign seq.cont        = cont_r;
    assign seq.trigger     = trigger_r;
    assign seq.fp_op       = fp_op_r;
endmodule

// File: tb/tb_front_panel_ctl.sv
// Directed + randomized bench for front_panel_ctl with a window-based
// debounce reference model and a bench-side sequencer.
module tb_front_panel_ctl;
    import front_panel_ctl_pkg::*;

    localparam int DEB = 16;

    logic clk = 1'b0;
    logic reset;
    logic sw_halt, sw_sing_step, sw_cont, sw_addr_load, sw_exam, sw_dep;

    front_panel_ctl_if bus ();

    front_panel_ctl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_halt     (sw_halt),
        .sw_sing_step(sw_sing_step),
        .sw_cont     (sw_cont),
        .sw_addr_load(sw_addr_load),
        .sw_exam     (sw_exam),
        .sw_dep      (sw_dep),
        .seq         (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_rst = 0;
    bit   seen_rst = 1'b0;
    logic m_halt = 1'b0;
    logic m_ss = 1'b0;
    logic prev_trig = 1'b0;
    logic prev_cont = 1'b0;
    int   trig_rises = 0;
    int   cont_pulses = 0;
    logic hist_h [0:8191];
    logic hist_s [0:8191];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A debounced level flips once the raw switch, as seen at the synchronizer
    // output, has disagreed with it for DEB consecutive clocks since reset.
    function automatic logic deb_next(input logic cur, input int k, input bit sel);
        logic all_diff;
        logic v;
        all_diff = 1'b1;
        if (k < last_rst + DEB) return cur;
        for (int i = k - DEB - 1; i <= k - 2; i++) begin
            v = sel ? hist_s[i] : hist_h[i];
            if (v === cur) all_diff = 1'b0;
        end
        return all_diff ? ~cur : cur;
    endfunction

    task automatic tick();
        logic rst_at_edge;
        if (cyc >= 8000) begin
            $display("FAIL cycle_budget observed=%0d limit=8000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        hist_h[cyc+1] = sw_halt;
        hist_s[cyc+1] = sw_sing_step;
        rst_at_edge   = reset;
        @(posedge clk);
        cyc++;
        if (rst_at_edge) begin
            m_halt   = 1'b0;
            m_ss     = 1'b0;
            last_rst = cyc;
            seen_rst = 1'b1;
        end else if (seen_rst) begin
            m_halt = deb_next(m_halt, cyc, 1'b0);
            m_ss   = deb_next(m_ss, cyc, 1'b1);
        end
        #1;
        if (seen_rst) begin
            chk("halt_model", 32'(bus.halt), 32'(m_halt));
            chk("single_step_model", 32'(bus.single_step), 32'(m_ss));
            chk("cont_and_trigger", 32'(bus.cont & bus.trigger), 32'd0);
            chk("cont_width", 32'(bus.cont & prev_cont), 32'd0);
        end
        if (bus.trigger === 1'b1 && prev_trig !== 1'b1) trig_rises++;
        if (bus.cont === 1'b1 && prev_cont !== 1'b1) cont_pulses++;
        prev_trig = bus.trigger;
        prev_cont = bus.cont;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_trig(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.trigger === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Bench sequencer walks H1, H2, H3, H0 after seeing trigger.
    task automatic run_handshake(input logic [1:0] op, input string tag);
        bus.state = H1;
        tick();
        chk({tag, "_trig_drop_h1"}, 32'(bus.trigger), 32'd0);
        chk({tag, "_fp_op_h1"}, 32'(bus.fp_op), 32'(op));
        bus.state = H2;
        ticks($urandom_range(1, 3));
        bus.state = H3;
        tick();
        chk({tag, "_fp_op_h3"}, 32'(bus.fp_op), 32'(op));
        bus.state = H0;
        tick();
        chk({tag, "_fp_op_clear_h0"}, 32'(bus.fp_op), 32'(FP_NONE));
    endtask

    initial begin
        int n;
        int t0;
        int c0;

        reset = 1'b1;
        sw_halt = 1'b0; sw_sing_step = 1'b0; sw_cont = 1'b0;
        sw_addr_load = 1'b0; sw_exam = 1'b0; sw_dep = 1'b0;
        bus.state = H0;
        ticks(4);
        reset = 1'b0;
        tick();
        chk("reset_trigger", 32'(bus.trigger), 32'd0);
        chk("reset_fp_op", 32'(bus.fp_op), 32'(FP_NONE));
        chk("reset_cont", 32'(bus.cont), 32'd0);

        // 1: glitch then steady HALT
        bus.state = F1;
        sw_halt = 1'b1; ticks(3);
        sw_halt = 1'b0; ticks(3);
        chk("t1_glitch_no_halt", 32'(bus.halt), 32'd0);
        sw_halt = 1'b1;
        ticks(DEB + 1);
        chk("t1_halt_not_early", 32'(bus.halt), 32'd0);
        tick();
        chk("t1_halt_at_18", 32'(bus.halt), 32'd1);
        ticks(12);

        // Randomized toggle activity on the two level switches
        for (int s = 0; s < 14; s++) begin
            sw_halt      = 1'($urandom_range(0, 1));
            sw_sing_step = 1'($urandom_range(0, 1));
            ticks($urandom_range(1, 40));
        end
        sw_halt = 1'b1; sw_sing_step = 1'b0;
        ticks(DEB + 8);

        // 2: EXAM at HW
        bus.state = HW;
        t0 = trig_rises;
        sw_exam = 1'b1;
        wait_trig(DEB + 12, n);
        chk("t2_trig_latency_ok", 32'((n >= DEB + 2) && (n <= DEB + 5)), 32'd1);
        chk("t2_fp_op_exam", 32'(bus.fp_op), 32'(FP_EXAM));
        ticks($urandom_range(1, 3));
        chk("t2_trig_held_hw", 32'(bus.trigger), 32'd1);
        run_handshake(FP_EXAM, "t2");
        bus.state = HW;
        ticks(20);
        sw_exam = 1'b0;
        ticks(DEB + 12);
        chk("t2_one_trigger", 32'(trig_rises - t0), 32'd1);

        // 3: DEP and CONT together at HW
        c0 = cont_pulses;
        t0 = trig_rises;
        sw_dep = 1'b1; sw_cont = 1'b1;
        wait_trig(DEB + 12, n);
        chk("t3_trig_seen", 32'(n > 0), 32'd1);
        chk("t3_fp_op_dep", 32'(bus.fp_op), 32'(FP_DEP));
        chk("t3_no_cont_before_op", 32'(cont_pulses - c0), 32'd0);
        run_handshake(FP_DEP, "t3");
        chk("t3_no_cont_during_op", 32'(cont_pulses - c0), 32'd0);
        bus.state = HW;
        ticks(3);
        chk("t3_cont_after_op", 32'(cont_pulses - c0), 32'd1);
        sw_dep = 1'b0; sw_cont = 1'b0;
        ticks(DEB + 20);
        chk("t3_single_cont", 32'(cont_pulses - c0), 32'd1);
        chk("t3_single_trig", 32'(trig_rises - t0), 32'd1);

        // 4: single-step continue at F0 / E0, none at F1
        sw_sing_step = 1'b1;
        ticks(DEB + 6);
        chk("t4_single_step_on", 32'(bus.single_step), 32'd1);
        c0 = cont_pulses;
        bus.state = F0;
        sw_cont = 1'b1; ticks(25); sw_cont = 1'b0; ticks(25);
        chk("t4_cont_f0", 32'(cont_pulses - c0), 32'd1);
        bus.state = E0;
        sw_cont = 1'b1; ticks(25); sw_cont = 1'b0; ticks(25);
        chk("t4_cont_e0", 32'(cont_pulses - c0), 32'd2);
        bus.state = F1;
        sw_cont = 1'b1; ticks(25); sw_cont = 1'b0; ticks(25);
        chk("t4_no_cont_f1", 32'(cont_pulses - c0), 32'd2);

        // 5: ADDR LOAD while running is dropped; pending cont still fires at HW
        t0 = trig_rises;
        c0 = cont_pulses;
        sw_addr_load = 1'b1; ticks(25); sw_addr_load = 1'b0; ticks(25);
        chk("t5_no_trig_running", 32'(trig_rises - t0), 32'd0);
        bus.state = HW;
        ticks(30);
        chk("t5_no_trig_at_hw", 32'(trig_rises - t0), 32'd0);
        chk("t5_pending_cont_fires", 32'(cont_pulses - c0), 32'd1);
        chk("t5_fp_op_idle", 32'(bus.fp_op), 32'(FP_NONE));

        // 6: reset while trigger is pending, key held through reset
        t0 = trig_rises;
        sw_exam = 1'b1;
        wait_trig(DEB + 12, n);
        chk("t6_trig_seen", 32'(n > 0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_trigger", 32'(bus.trigger), 32'd0);
        chk("t6_rst_fp_op", 32'(bus.fp_op), 32'(FP_NONE));
        chk("t6_rst_cont", 32'(bus.cont), 32'd0);
        chk("t6_rst_halt", 32'(bus.halt), 32'd0);
        chk("t6_rst_single_step", 32'(bus.single_step), 32'd0);
        ticks(40);
        chk("t6_no_trig_held", 32'(trig_rises - t0), 32'd1);
        sw_exam = 1'b0;
        ticks(DEB + 8);
        sw_exam = 1'b1;
        wait_trig(DEB + 12, n);
        chk("t6_retrig_seen", 32'(n > 0), 32'd1);
        chk("t6_retrig_fp_op", 32'(bus.fp_op), 32'(FP_EXAM));
        chk("t6_trig_count", 32'(trig_rises - t0), 32'd2);
        sw_exam = 1'b0;
        ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
